instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc_reg.sv | 30 +++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit and its PC register.
package fetch_pkg;

   localparam int INSTR_W    = 32;
   localparam int ADDR_W     = 32;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   localparam logic [OPCODE_W-1:0] DEF_HALT_OPCODE = 6'b111111;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, branch load and sequential increment, in that priority.
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_target,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= i_target;
      end else if (i_inc) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetcher: requests a word, holds it for the decoder,
// and redirects on branch, draining any in-flight request before refetching.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0]   RESET_PC    = 32'h0000_0000,
   parameter int unsigned         PC_STEP     = 4,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pc_src,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                instr_ready,
   output logic [15:0]         issued_cnt,
   output fetch_state_e        dbg_state
);

   fetch_state_e       r_state;
   fetch_state_e       w_next_state;
   logic [ADDR_W-1:0]  w_pc;
   logic [ADDR_W-1:0]  r_drain_addr;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic [15:0]        r_issued_cnt;
   logic               w_pc_load;
   logic               w_pc_inc;
   logic               w_capture;
   logic               w_count;
   logic               w_enter_drain;

   pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (ADDR_W'(PC_STEP))
   ) u_pc_reg (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_pc_load),
      .i_target (branch_target),
      .i_inc    (w_pc_inc),
      .o_pc     (w_pc)
   );

   // Handshakes: memory beat completes in any cycle with imem_req && imem_ack;
   // decoder transfer completes with instr_valid && instr_ready && !pc_src.
   always_comb begin
      w_next_state  = r_state;
      w_pc_load     = 1'b0;
      w_pc_inc      = 1'b0;
      w_capture     = 1'b0;
      w_count       = 1'b0;
      w_enter_drain = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (pc_src) begin
               w_pc_load     = 1'b1;
               w_enter_drain = !imem_ack;
               w_next_state  = imem_ack ? ST_FETCH : ST_DRAIN;
            end else if (imem_ack) begin
               w_capture    = 1'b1;
               w_pc_inc     = 1'b1;
               w_next_state = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            w_pc_load = pc_src;
            if (imem_ack) w_next_state = ST_FETCH;
         end
         ST_HOLD: begin
            if (pc_src) begin
               w_pc_load    = 1'b1;
               w_next_state = ST_FETCH;
            end else if (instr_ready) begin
               w_count      = 1'b1;
               w_next_state = (get_opcode(r_instr) == HALT_OPCODE) ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_FETCH;
         r_drain_addr <= '0;
         r_instr      <= '0;
         r_instr_pc   <= '0;
         r_issued_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         // The drained request keeps its original address while pc tracks the redirect.
         if (w_enter_drain) r_drain_addr <= w_pc;
         if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= w_pc;
         end
         if (w_count) r_issued_cnt <= r_issued_cnt + 16'd1;
      end
   end

   assign imem_req    = reset && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
   assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : w_pc;
   assign instr_valid = (r_state == ST_HOLD);
   assign instr       = r_instr;
   assign opcode      = get_opcode(r_instr);
   assign instr_pc    = r_instr_pc;
   assign issued_cnt  = r_issued_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against an address-stream reference model.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         pc_src;
   logic [31:0]  branch_target;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_ack;
   logic [31:0]  imem_rdata;
   logic         instr_valid;
   logic [31:0]  instr;
   logic [5:0]   opcode;
   logic [31:0]  instr_pc;
   logic         instr_ready;
   logic [15:0]  issued_cnt;
   fetch_state_e dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state for the random phase
   logic [31:0] exp_next;
   logic [15:0] m_cnt;
   logic        prev_pending;
   logic [31:0] prev_addr;
   logic        busy;
   int          waited;
   int          delay;

   instr_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .opcode        (opcode),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready),
      .issued_cnt    (issued_cnt),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // memory contents: never carries the halt opcode
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [5:0] op;
      op = addr[7:2];
      if (op == 6'h3F) op = 6'h15;
      return {op, addr[27:2]};
   endfunction

   // From a FETCH cycle: wait `dly` cycles, then ack with `data`; leaves the DUT in HOLD.
   task automatic fetch_one(input int dly, input logic [31:0] data, input logic [31:0] addr);
      for (int i = 0; i < dly; i++) begin
         imem_ack = 1'b0;
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, addr);
         tick();
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      chk("ack_addr", imem_addr, addr);
      tick();
      imem_ack = 1'b0;
      chk("lat_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", instr, data);
      chk("hold_pc", instr_pc, addr);
      chk("hold_opcode", {26'b0, opcode}, {26'b0, data[31:26]});
   endtask

   initial begin
      reset = 1'b0; pc_src = 1'b0; branch_target = '0;
      imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

      // reset
      tick(); tick();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_cnt", {16'b0, issued_cnt}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      reset = 1'b1;
      #1;
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // two sequential fetches, ready held
      instr_ready = 1'b1;
      fetch_one(1, 32'h0400_0001, 32'h0);
      tick();
      chk("seq_cnt1", {16'b0, issued_cnt}, 32'd1);
      chk("seq_addr2", imem_addr, 32'h4);
      fetch_one(1, 32'h0400_0002, 32'h4);
      tick();
      chk("seq_cnt2", {16'b0, issued_cnt}, 32'd2);

      // decoder stall
      instr_ready = 1'b0;
      fetch_one(2, 32'h0400_0003, 32'h8);
      repeat (5) begin
         tick();
         chk("stall_valid", {31'b0, instr_valid}, 32'd1);
         chk("stall_instr", instr, 32'h0400_0003);
         chk("stall_pc", instr_pc, 32'h8);
      end
      chk("stall_cnt", {16'b0, issued_cnt}, 32'd2);
      instr_ready = 1'b1;
      tick();
      chk("stall_done_valid", {31'b0, instr_valid}, 32'd0);
      chk("stall_done_cnt", {16'b0, issued_cnt}, 32'd3);

      // branch while a request is in flight
      pc_src = 1'b1; branch_target = 32'h100; imem_ack = 1'b0;
      chk("drain_addr0", imem_addr, 32'hC);
      tick();
      pc_src = 1'b0;
      repeat (2) begin
         chk("drain_req", {31'b0, imem_req}, 32'd1);
         chk("drain_addr", imem_addr, 32'hC);
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_BAD0;
      chk("drain_ack_addr", imem_addr, 32'hC);
      tick();
      imem_ack = 1'b0;
      chk("drain_drop", {31'b0, instr_valid}, 32'd0);
      chk("drain_next_req", {31'b0, imem_req}, 32'd1);
      chk("drain_next_addr", imem_addr, 32'h100);
      fetch_one(0, 32'h0400_0004, 32'h100);

      // branch in HOLD beats a same-cycle ready
      pc_src = 1'b1; branch_target = 32'h100; instr_ready = 1'b1;
      tick();
      pc_src = 1'b0;
      chk("hold_br_valid", {31'b0, instr_valid}, 32'd0);
      chk("hold_br_cnt", {16'b0, issued_cnt}, 32'd3);
      chk("hold_br_addr", imem_addr, 32'h100);

      // branch together with ack in FETCH
      pc_src = 1'b1; branch_target = 32'h300; imem_ack = 1'b1; imem_rdata = 32'h0400_0005;
      tick();
      pc_src = 1'b0; imem_ack = 1'b0;
      chk("fb_valid", {31'b0, instr_valid}, 32'd0);
      chk("fb_req", {31'b0, imem_req}, 32'd1);
      chk("fb_addr", imem_addr, 32'h300);

      // counter wrap
      force dut.r_issued_cnt = 16'hFFFF;
      #1;
      release dut.r_issued_cnt;
      #1;
      chk("wrap_pre", {16'b0, issued_cnt}, 32'h0000_FFFF);
      fetch_one(0, 32'h0400_0006, 32'h300);
      tick();
      chk("wrap_cnt", {16'b0, issued_cnt}, 32'd0);

      // randomized traffic against the address-stream model
      exp_next = 32'h304; m_cnt = '0; prev_pending = 1'b0; prev_addr = '0;
      busy = 1'b0; waited = 0; delay = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rand_cnt", {16'b0, issued_cnt}, {16'b0, m_cnt});
         if (prev_pending) begin
            chk("rand_req_hold", {31'b0, imem_req}, 32'd1);
            chk("rand_addr_hold", imem_addr, prev_addr);
         end
         pc_src        = ($urandom_range(0, 11) == 0);
         branch_target = $urandom_range(0, 1023) << 2;
         instr_ready   = ($urandom_range(0, 3) != 0);
         if (imem_req && !busy) begin
            busy = 1'b1; waited = 0; delay = $urandom_range(0, 3);
         end
         imem_ack   = busy && (waited == delay);
         imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
         #1;
         if (pc_src) begin
            exp_next = branch_target;
         end else if (instr_valid && instr_ready) begin
            chk("rand_pc", instr_pc, exp_next);
            chk("rand_instr", instr, mem_word(exp_next));
            m_cnt    = m_cnt + 16'd1;
            exp_next = exp_next + 32'd4;
         end
         prev_pending = imem_req && !imem_ack;
         prev_addr    = imem_addr;
         if (imem_ack) busy = 1'b0;
         else if (busy) waited++;
         tick();
      end
      chk("rand_progress", {31'b0, (m_cnt > 16'd200)}, 32'd1);

      // halt, then leave only by reset
      pc_src = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("rst2_addr", imem_addr, 32'h0);
      fetch_one(0, 32'hFC00_0000, 32'h0);
      tick();
      chk("halt_cnt", {16'b0, issued_cnt}, 32'd1);
      chk("halt_state", {30'b0, dbg_state}, {30'b0, ST_HALT});
      for (int i = 0; i < 20; i++) begin
         pc_src        = (i % 3 == 0);
         branch_target = $urandom_range(0, 255) << 2;
         tick();
         chk("halt_req", {31'b0, imem_req}, 32'd0);
         chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      end
      pc_src = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("rst3_req", {31'b0, imem_req}, 32'd0);
      chk("rst3_cnt", {16'b0, issued_cnt}, 32'd0);
      reset = 1'b1;
      #1;
      chk("rst3_req_up", {31'b0, imem_req}, 32'd1);
      chk("rst3_addr", imem_addr, 32'h0);

      // reset mid-request, then a late ack counts for RESET_PC
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h0400_0007;
      #1;
      chk("late_addr", imem_addr, 32'h0);
      tick();
      imem_ack = 1'b0;
      chk("late_valid", {31'b0, instr_valid}, 32'd1);
      chk("late_pc", instr_pc, 32'h0);
      chk("late_instr", instr, 32'h0400_0007);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
